// File: rtl/rotary_pkg.sv
// Shared helpers for position consumers fed by the rotary encoder driver.
// rot_step applies one bounded step with either saturate or wrap behaviour.
package rotary_pkg;

  localparam int ROT_SATURATE = 0;
  localparam int ROT_WRAP     = 1;

  // Wide enough for any supported position width plus one guard bit.
  localparam int ROT_W = 32;
  typedef logic [ROT_W:0] rot_val_t;
  localparam rot_val_t ROT_ONE = rot_val_t'(1);

  function automatic rot_val_t rot_step(
    input rot_val_t v,
    input rot_val_t s,
    input logic     dir,
    input rot_val_t min_v,
    input rot_val_t max_v,
    input logic     wrap
  );
    rot_val_t sum;
    rot_val_t room;
    if (dir) begin
      sum = v + s;
      if (sum > max_v) return wrap ? min_v + (sum - max_v - ROT_ONE) : max_v;
      return sum;
    end
    // Compare against the headroom first so nothing ever goes below zero.
    room = v - min_v;
    if (s > room) return wrap ? max_v - (s - room - ROT_ONE) : min_v;
    return v - s;
  endfunction

endpackage

// File: rtl/rotary_accel.sv
// Speed tracker: measures the gap between accepted steps and the run of fast
// same-direction steps, and turns that into a step size and fast flag.
module rotary_accel #(
  parameter int WIDTH        = 8,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_STREAK = 4,
  parameter int ACCEL_STEP   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           step,
  input  logic           step_cw,
  input  logic           load,
  output logic [WIDTH:0] step_size,
  output logic           fast
);

  localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
  localparam int STK_W = $clog2(ACCEL_STREAK + 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(ACCEL_WINDOW);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [STK_W-1:0] STK_FULL = STK_W'(ACCEL_STREAK);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

  logic [GAP_W-1:0] gap_p1;
  logic [STK_W-1:0] streak_p1;
  logic [STK_W-1:0] streak_p0;
  logic             last_cw_p1;
  logic             quick;

  always_comb begin
    quick     = (gap_p1 < GAP_SAT) && (step_cw == last_cw_p1);
    streak_p0 = STK_ONE;
    if (quick) streak_p0 = (streak_p1 == STK_FULL) ? STK_FULL : streak_p1 + STK_ONE;
    step_size = (streak_p0 == STK_FULL) ? (WIDTH+1)'(ACCEL_STEP) : (WIDTH+1)'(1);
  end

  // Stage p1: gap counter, streak and direction history
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gap_p1     <= GAP_SAT;
      streak_p1  <= '0;
      last_cw_p1 <= 1'b0;
      fast       <= 1'b0;
    end else if (load) begin
      gap_p1    <= GAP_SAT;
      streak_p1 <= '0;
      fast      <= 1'b0;
    end else if (step) begin
      gap_p1     <= '0;
      streak_p1  <= streak_p0;
      last_cw_p1 <= step_cw;
      fast       <= (streak_p0 == STK_FULL);
    end else if (gap_p1 != GAP_SAT) begin
      gap_p1 <= gap_p1 + GAP_ONE;
      // The window expires as the gap saturates: acceleration ends right there.
      if (gap_p1 == GAP_SAT - GAP_ONE) begin
        streak_p1 <= '0;
        fast      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rotary_position_counter.sv
// Bounded position register driven by encoder step pulses, with preset load,
// saturate/wrap range handling and speed-dependent step size.
module rotary_position_counter
  import rotary_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN          = 0,
  parameter int MAX          = 255,
  parameter int INIT         = 0,
  parameter int WRAP         = ROT_SATURATE,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_STREAK = 4,
  parameter int ACCEL_STEP   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cnt,
  input  logic             i_cnt_cw,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_changed,
  output logic             o_at_min,
  output logic             o_at_max,
  output logic             o_fast
);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic             WRAP_EN = (WRAP == ROT_WRAP);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] bounded_step(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH:0]   s,
    input logic             dir
  );
    return WIDTH'(rot_step(rot_val_t'(v), rot_val_t'(s), dir,
                           rot_val_t'(MIN_V), rot_val_t'(MAX_V), WRAP_EN));
  endfunction

  logic             step;
  logic [WIDTH:0]   step_size;
  logic [WIDTH-1:0] value_p0;
  logic [WIDTH-1:0] value_p1;
  logic             changed_p1;

  assign step = i_cnt & ~i_load;

  rotary_accel #(
    .WIDTH        (WIDTH),
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .ACCEL_STREAK (ACCEL_STREAK),
    .ACCEL_STEP   (ACCEL_STEP)
  ) u_accel (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .step      (step),
    .step_cw   (i_cnt_cw),
    .load      (i_load),
    .step_size (step_size),
    .fast      (o_fast)
  );

  // Stage p0: next position, load wins over a coincident step
  always_comb begin
    value_p0 = value_p1;
    if (i_load)     value_p0 = clamp_load(i_load_value);
    else if (i_cnt) value_p0 = bounded_step(value_p1, step_size, i_cnt_cw);
  end

  // Stage p1: registered position and change pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_p1   <= INIT_V;
      changed_p1 <= 1'b0;
    end else begin
      value_p1   <= value_p0;
      changed_p1 <= (value_p0 != value_p1);
    end
  end

  assign o_value   = value_p1;
  assign o_changed = changed_p1;
  assign o_at_min  = (value_p1 == MIN_V);
  assign o_at_max  = (value_p1 == MAX_V);

endmodule

// File: tb/tb_rotary_position_counter.sv
// Three differently configured counters checked each cycle against a
// timestamp-based behavioural model, plus hand-computed directed checks.
module tb_rotary_position_counter;

  localparam int P_MIN[3]  = '{0, 2, 0};
  localparam int P_MAX[3]  = '{15, 9, 200};
  localparam int P_INIT[3] = '{10, 3, 0};
  localparam int P_WRAP[3] = '{0, 1, 0};
  localparam int P_WIN[3]  = '{100, 8, 100};
  localparam int P_STK     = 4;
  localparam int P_STEP    = 4;
  localparam int NEVER     = -1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt[3];
  logic       cw[3];
  logic       ld[3];
  logic [8:0] lv[3];
  logic [7:0] va, vb;
  logic [8:0] vc;
  logic       chg[3], amin[3], amax[3], fst[3];
  int         dv[3];

  int n_chk  = 0;
  int n_fail = 0;

  int   m_val[3], m_streak[3], m_dir[3], m_last[3];
  logic m_chg[3], m_fast[3];
  int   edge_n;

  int seq_a[4]   = '{4, 3, 2, 0};
  int seq_b[5]   = '{3, 4, 5, 9, 5};
  int seq_bf[5]  = '{0, 0, 0, 1, 1};
  int seq_c[5]   = '{101, 102, 103, 107, 111};
  int seq_cf[5]  = '{0, 0, 0, 1, 1};
  int seq_cd[4]  = '{199, 198, 197, 193};

  always #5 clk = ~clk;

  rotary_position_counter #(
    .WIDTH(8), .MIN(P_MIN[0]), .MAX(P_MAX[0]), .INIT(P_INIT[0]), .WRAP(P_WRAP[0]),
    .ACCEL_WINDOW(P_WIN[0]), .ACCEL_STREAK(P_STK), .ACCEL_STEP(P_STEP)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt[0]), .i_cnt_cw(cw[0]), .i_load(ld[0]),
    .i_load_value(lv[0][7:0]), .o_value(va), .o_changed(chg[0]), .o_at_min(amin[0]),
    .o_at_max(amax[0]), .o_fast(fst[0])
  );

  rotary_position_counter #(
    .WIDTH(8), .MIN(P_MIN[1]), .MAX(P_MAX[1]), .INIT(P_INIT[1]), .WRAP(P_WRAP[1]),
    .ACCEL_WINDOW(P_WIN[1]), .ACCEL_STREAK(P_STK), .ACCEL_STEP(P_STEP)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt[1]), .i_cnt_cw(cw[1]), .i_load(ld[1]),
    .i_load_value(lv[1][7:0]), .o_value(vb), .o_changed(chg[1]), .o_at_min(amin[1]),
    .o_at_max(amax[1]), .o_fast(fst[1])
  );

  rotary_position_counter #(
    .WIDTH(9), .MIN(P_MIN[2]), .MAX(P_MAX[2]), .INIT(P_INIT[2]), .WRAP(P_WRAP[2]),
    .ACCEL_WINDOW(P_WIN[2]), .ACCEL_STREAK(P_STK), .ACCEL_STEP(P_STEP)
  ) u_c (
    .i_clk(clk), .i_rst(rst), .i_cnt(cnt[2]), .i_cnt_cw(cw[2]), .i_load(ld[2]),
    .i_load_value(lv[2]), .o_value(vc), .o_changed(chg[2]), .o_at_min(amin[2]),
    .o_at_max(amax[2]), .o_fast(fst[2])
  );

  always_comb begin
    dv[0] = int'(va);
    dv[1] = int'(vb);
    dv[2] = int'(vc);
  end

  // Model: steps are fast when they arrive within the window (in edges) of the
  // previous accepted step; wrap is plain modular arithmetic over the range.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n <= 0;
      for (int i = 0; i < 3; i++) begin
        m_val[i]    <= P_INIT[i];
        m_streak[i] <= 0;
        m_dir[i]    <= 0;
        m_last[i]   <= NEVER;
        m_chg[i]    <= 1'b0;
        m_fast[i]   <= 1'b0;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < 3; i++) begin
        automatic int now = edge_n + 1;
        automatic int nv  = m_val[i];
        automatic int rng = P_MAX[i] - P_MIN[i] + 1;
        automatic int st  = 1;
        automatic int s   = 1;
        if (ld[i]) begin
          nv = int'(lv[i]);
          if (nv > P_MAX[i]) nv = P_MAX[i];
          if (nv < P_MIN[i]) nv = P_MIN[i];
          m_streak[i] <= 0;
          m_fast[i]   <= 1'b0;
          m_last[i]   <= NEVER;
        end else if (cnt[i]) begin
          if ((now - m_last[i] <= P_WIN[i]) && (int'(cw[i]) == m_dir[i]))
            st = (m_streak[i] + 1 > P_STK) ? P_STK : m_streak[i] + 1;
          s = (st == P_STK) ? P_STEP : 1;
          if (cw[i]) begin
            nv = m_val[i] + s;
            if (nv > P_MAX[i]) nv = (P_WRAP[i] != 0) ? nv - rng : P_MAX[i];
          end else begin
            nv = m_val[i] - s;
            if (nv < P_MIN[i]) nv = (P_WRAP[i] != 0) ? nv + rng : P_MIN[i];
          end
          m_streak[i] <= st;
          m_fast[i]   <= (st == P_STK);
          m_dir[i]    <= int'(cw[i]);
          m_last[i]   <= now;
        end else if (now - m_last[i] >= P_WIN[i]) begin
          m_streak[i] <= 0;
          m_fast[i]   <= 1'b0;
        end
        m_chg[i] <= (nv != m_val[i]);
        m_val[i] <= nv;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model value[%0d]", i), dv[i], m_val[i]);
        chk($sformatf("model changed[%0d]", i), int'(chg[i]), int'(m_chg[i]));
        chk($sformatf("model fast[%0d]", i), int'(fst[i]), int'(m_fast[i]));
        chk($sformatf("model at_min[%0d]", i), int'(amin[i]), int'(m_val[i] == P_MIN[i]));
        chk($sformatf("model at_max[%0d]", i), int'(amax[i]), int'(m_val[i] == P_MAX[i]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int d, input logic dir);
    cnt[d] = 1'b1;
    cw[d]  = dir;
    @(negedge clk);
    cnt[d] = 1'b0;
  endtask

  task automatic load(input int d, input int v);
    ld[d] = 1'b1;
    lv[d] = 9'(v);
    @(negedge clk);
    ld[d] = 1'b0;
  endtask

  task automatic expv(input string nm, input int d, input int v, input int c, input int f);
    chk({nm, " value"}, dv[d], v);
    chk({nm, " changed"}, int'(chg[d]), c);
    chk({nm, " fast"}, int'(fst[d]), f);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 1'b0;
      cw[i]  = 1'b0;
      ld[i]  = 1'b0;
      lv[i]  = '0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    expv("A reset", 0, 10, 0, 0);
    chk("A reset at_min", int'(amin[0]), 0);
    chk("B reset value", dv[1], 3);
    chk("C reset at_min", int'(amin[2]), 1);

    // Saturation at the top of 0..15
    load(0, 14);
    expv("A load 14", 0, 14, 1, 0);
    idle(150); step(0, 1'b1);
    expv("A sat step1", 0, 15, 1, 0);
    chk("A sat at_max", int'(amax[0]), 1);
    idle(150); step(0, 1'b1);
    expv("A sat step2", 0, 15, 0, 0);
    idle(150); step(0, 1'b1);
    expv("A sat step3", 0, 15, 0, 0);

    // Back-to-back CCW into the floor; accelerated step clamps at MIN
    load(0, 5);
    expv("A load 5", 0, 5, 1, 0);
    cnt[0] = 1'b1; cw[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expv($sformatf("A floor %0d", k), 0, seq_a[k], 1, (k == 3) ? 1 : 0);
    end
    cnt[0] = 1'b0;

    // Wrap on 2..9
    step(1, 1'b0);
    expv("B wrap ccw1", 1, 2, 1, 0);
    chk("B at_min", int'(amin[1]), 1);
    idle(20); step(1, 1'b0);
    expv("B wrap ccw2", 1, 9, 1, 0);
    chk("B at_max", int'(amax[1]), 1);
    idle(20); step(1, 1'b1);
    expv("B wrap cw", 1, 2, 1, 0);
    idle(20);
    cnt[1] = 1'b1; cw[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expv($sformatf("B burst %0d", k), 1, seq_b[k], 1, seq_bf[k]);
    end
    cw[1] = 1'b0;
    @(negedge clk);
    cnt[1] = 1'b0;
    expv("B reverse", 1, 4, 1, 0);

    // Acceleration with steps 20 cycles apart
    load(2, 100);
    expv("C load 100", 2, 100, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(2, 1'b1);
      expv($sformatf("C accel %0d", k), 2, seq_c[k], 1, seq_cf[k]);
      if (k < 4) idle(19);
    end
    idle(99);
    chk("C fast before window end", int'(fst[2]), 1);
    idle(1);
    chk("C fast after window end", int'(fst[2]), 0);
    step(2, 1'b1);
    expv("C slow after idle", 2, 112, 1, 0);

    // Reversal mid-streak
    idle(19); step(2, 1'b1); expv("C rebuild 2", 2, 113, 1, 0);
    idle(19); step(2, 1'b1); expv("C rebuild 3", 2, 114, 1, 0);
    idle(19); step(2, 1'b1); expv("C rebuild 4", 2, 118, 1, 1);
    idle(19); step(2, 1'b0); expv("C reversal", 2, 117, 1, 0);

    // Load beats a coincident step and clamps to MAX
    idle(150);
    load(2, 50);
    expv("C load 50", 2, 50, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      idle(19); step(2, 1'b1);
      expv($sformatf("C pre-load step %0d", k), 2, 50 + k, 1, 0);
    end
    idle(19);
    cnt[2] = 1'b1; cw[2] = 1'b1; ld[2] = 1'b1; lv[2] = 9'(300);
    @(negedge clk);
    cnt[2] = 1'b0; ld[2] = 1'b0;
    expv("C load priority", 2, 200, 1, 0);
    chk("C load at_max", int'(amax[2]), 1);
    idle(19); step(2, 1'b1);
    expv("C streak cleared", 2, 200, 0, 0);

    cnt[2] = 1'b1; cw[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expv($sformatf("C ccw burst %0d", k), 2, seq_cd[k], 1, (k == 3) ? 1 : 0);
    end

    // Asynchronous reset between edges during a fast streak
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cnt[2] = 1'b0;
    expv("C async reset", 2, 0, 0, 0);
    chk("A async reset value", dv[0], 10);
    chk("B async reset value", dv[1], 3);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("C after reset release", dv[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotary_position_counter.md
# rotary_position_counter

Consumes the one-cycle step pulses (step strobe plus direction) produced by the incremental rotary encoder driver and turns them into a bounded position value. Supports saturating or wrap-around ranges, speed-dependent acceleration and a synchronous preset load. Sits directly downstream of the encoder driver and feeds user-facing logic such as a volume or menu index.

## Interface
- WIDTH, 8: width of the position value.
- MIN, 0: lowest legal position; 0 ≤ MIN ≤ MAX < 2^WIDTH.
- MAX, 255: highest legal position.
- INIT, 0: reset position; must lie within [MIN, MAX].
- WRAP, 0: 0 = saturate at bounds, 1 = wrap around.
- ACCEL_WINDOW, 50000: maximum step-to-step gap, in cycles, still counted as "fast".
- ACCEL_STREAK, 4: consecutive fast same-direction steps needed to enter acceleration.
- ACCEL_STEP, 4: step size while accelerating; 1 ≤ ACCEL_STEP ≤ MAX−MIN+1.
- i_clk  in  1  the single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_cnt  in  1  one-cycle step strobe from the encoder driver.
- i_cnt_cw  in  1  direction, qualified by i_cnt: 1 = clockwise = increment.
- i_load  in  1  synchronous preset strobe.
- i_load_value  in  WIDTH  preset value.
- o_value  out  WIDTH  current position, registered.
- o_changed  out  1  one-cycle pulse when o_value changed.
- o_at_min  out  1  o_value == MIN.
- o_at_max  out  1  o_value == MAX.
- o_fast  out  1  acceleration active.

## Operation
- Reset:
  - o_value = INIT, o_changed = 0, o_fast = 0.
  - Gap counter saturated (treated as "slow"); streak = 0; last direction = 0.
  - o_at_min and o_at_max follow the reset o_value.
- Gap counter:
  - Increments every cycle and saturates at ACCEL_WINDOW.
  - Cleared to 0 on an accepted step.
  - On reaching ACCEL_WINDOW: streak = 0 and o_fast = 0.
- Accepted step: i_cnt = 1 and i_load = 0.
  - If gap < ACCEL_WINDOW and i_cnt_cw equals the last direction: streak = min(streak+1, ACCEL_STREAK).
  - Otherwise: streak = 1.
  - Last direction = i_cnt_cw.
- Step size = ACCEL_STEP if the updated streak equals ACCEL_STREAK, else 1. o_fast = (updated streak == ACCEL_STREAK).
- Arithmetic:
  - Computed in WIDTH+1 bits, so there is no intermediate overflow.
  - Increment, saturate: min(v+s, MAX).
  - Increment, wrap: v+s > MAX → MIN + (v+s−MAX−1).
  - Decrement, saturate: max(v−s, MIN).
  - Decrement, wrap: v−s < MIN → MAX − (MIN−(v−s)−1).
  - Underflow below 0 is handled by comparing s > v−MIN before subtracting.
- Load:
  - i_load has priority over a simultaneous step; that step is dropped.
  - The loaded value is clamped to [MIN, MAX].
  - Load clears streak and o_fast and saturates the gap counter.
- o_changed is asserted only when the new o_value differs from the old one.
  - A saturated step that stays at the bound does not pulse.
  - A load of the current value does not pulse.
- Reset mid-operation returns immediately to the reset state. Any in-flight strobe is lost.

## Timing
- A step or load sampled at edge N updates o_value at edge N, visible in cycle N+1.
  - o_changed is high for exactly cycle N+1.
  - o_fast updates in the same cycle.
- o_at_min and o_at_max are combinational from the o_value register, so they add no extra latency.
- Back-to-back strobes on consecutive cycles are each accepted; the driver never produces these, but the block must not drop them.
- Throughput: one step per cycle.

## Structure
- Shared package rotary_pkg:
  - WRAP mode constants ROT_SATURATE and ROT_WRAP.
  - Function rot_step(v, s, dir, min, max, wrap) with the wrap/saturate arithmetic, reused by other position consumers.
- One sub-module, rotary_accel:
  - Contains the gap counter, streak counter and last direction.
  - Outputs step size and fast flag.
- The top level holds the value register, load and clamp logic, and the output flags.

## Test plan
- Reset with INIT=10 → o_value=10, o_changed=0, o_fast=0, o_at_min=0.
- Saturation, MIN=0, MAX=15, WRAP=0, value 14: three slow CW steps (gap > ACCEL_WINDOW) → 15, 15, 15; o_changed pulses once; o_at_max=1.
- Wrap, MIN=2, MAX=9, WRAP=1, value 3:
  - Two slow CCW steps → 2, then 9.
  - A slow CW step from 9 → 2.
- Acceleration, ACCEL_WINDOW=100, ACCEL_STREAK=4, ACCEL_STEP=4, value 100: CW steps 20 cycles apart → 101, 102, 103, 107 (o_fast rises), 111.
  - Idle 100 cycles → o_fast falls.
  - The next step gives 112.
- Direction reversal mid-streak: after reaching o_fast, one fast CCW step → value −1, o_fast=0.
- Load priority: i_load=1 with i_load_value=300 (WIDTH=9, MAX=200) in the same cycle as a CW step from 50 → o_value=200, one o_changed pulse, streak cleared.
- Asynchronous reset asserted between clock edges during a fast streak → o_value=INIT immediately, without waiting for a clock edge; o_fast=0.
